// File: rtl/msk_ref_pkg.sv
// Shared constants and mask construction for the multi-bit SNI refresh pipe.
package msk_ref_pkg;

  localparam int unsigned D_MAX = 16;
  localparam int unsigned R_MAX = 2 * D_MAX;

  // Second-layer pairs for d>=6: extra random k is XORed into
  // shares k and (k + L2_DIST[k]) mod d.
  localparam int unsigned L2_DIST [D_MAX] = '{2, 3, 2, 3, 2, 3, 2, 3,
                                              2, 3, 2, 3, 2, 3, 2, 3};

  // Random bits consumed per lane for a d-share refresh.
  function automatic int unsigned ref_n_rnd(input int unsigned nd);
    case (nd)
      2:       return 1;
      3:       return 2;
      4:       return 4;
      5:       return 5;
      6:       return 7;
      7:       return 9;
      8:       return 11;
      9:       return 12;
      10:      return 15;
      11:      return 17;
      12:      return 20;
      default: return 2 * nd;
    endcase
  endfunction

  // Zero-sum mask for one lane; only bits [nd-1:0] are meaningful.
  function automatic logic [D_MAX-1:0] ref_mask(input int unsigned nd,
                                                input logic [R_MAX-1:0] r);
    logic [D_MAX-1:0] m;
    int unsigned      b;
    m = '0;
    case (nd)
      2: m[1:0] = {r[0], r[0]};
      3: m[2:0] = {r[0] ^ r[1], r[1], r[0]};
      default: begin
        // Ring: r ^ rotl1(r), every random bit lands on two adjacent shares.
        for (int unsigned i = 0; i < D_MAX; i++) begin
          if (i < nd) m[i] = r[i] ^ r[(i + nd - 1) % nd];
        end
        if (nd >= 6) begin
          for (int unsigned k = 0; k < D_MAX; k++) begin
            if (k < ref_n_rnd(nd) - nd) begin
              b    = (k + L2_DIST[k]) % nd;
              m[k] = m[k] ^ r[nd + k];
              m[b] = m[b] ^ r[nd + k];
            end
          end
        end
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/msk_ref_lane.sv
// One masked lane: registers the sharing and its mask, then applies the mask.
module msk_ref_lane
  import msk_ref_pkg::*;
#(
  parameter int unsigned d = 2,
  parameter int unsigned R = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load1,
  input  logic         mode,
  input  logic [d-1:0] shares_in,
  input  logic [R-1:0] rnd,
  input  logic         load2,
  output logic [d-1:0] shares_out
);

  logic [R_MAX-1:0] rnd_ext;
  logic [D_MAX-1:0] mask_full;
  logic             unused_mask;
  logic [d-1:0]     sh1;
  logic [d-1:0]     mask1;

  assign rnd_ext     = R_MAX'(rnd);
  assign mask_full   = ref_mask(d, rnd_ext);
  assign unused_mask = ^(mask_full >> d);

  // Stage 1 holds shares and mask apart; stage 2 is the only place they meet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so no share value from before
      // reset can ever reach out_shares.
      sh1        <= '0;
      mask1      <= '0;
      shares_out <= '0;
    end else begin
      // NOTE: non-blocking assignments keep stage 2 reading the old sh1/mask1
      // in the same edge that stage 1 reloads them.
      if (load1) begin
        sh1   <= shares_in;
        mask1 <= mode ? mask_full[d-1:0] : '0;
      end
      if (load2) shares_out <= sh1 ^ mask1;
    end
  end

endmodule

// File: rtl/msk_ref_sni_pipe.sv
// W-lane SNI refresh behind a 2-stage valid/ready pipe with its own
// randomness handshake and a refresh transfer counter.
module msk_ref_sni_pipe
  import msk_ref_pkg::*;
#(
  parameter  int unsigned d  = 2,
  parameter  int unsigned W  = 8,
  parameter  int unsigned CW = 16,
  localparam int unsigned R  = ref_n_rnd(d)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_mode,
  input  logic [W*d-1:0] in_shares,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  input  logic [W*R-1:0] rnd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W*d-1:0] out_shares,
  output logic [CW-1:0]  ref_cnt
);

  if (d < 2 || d > D_MAX) begin : g_bad_d
    $error("msk_ref_sni_pipe: d=%0d outside 2..%0d", d, D_MAX);
  end
  if (W < 1) begin : g_bad_w
    $error("msk_ref_sni_pipe: W must be at least 1");
  end

  logic v1;
  logic mode1;
  logic mode2;
  logic s2_load;
  logic s1_free;
  logic accept;

  assign s2_load   = v1 && (!out_valid || out_ready);
  assign s1_free   = !v1 || s2_load;
  assign in_ready  = s1_free && (rnd_valid || !in_mode);
  assign accept    = in_valid && in_ready;
  assign rnd_ready = accept && in_mode;

  // Pipeline occupancy, carried mode, and the refresh transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      mode1     <= 1'b0;
      mode2     <= 1'b0;
      out_valid <= 1'b0;
      ref_cnt   <= '0;
    end else begin
      if (accept)       v1 <= 1'b1;
      else if (s2_load) v1 <= 1'b0;
      if (accept) mode1 <= in_mode;

      if (s2_load) begin
        out_valid <= 1'b1;
        mode2     <= mode1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready && mode2) ref_cnt <= ref_cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_lane
    msk_ref_lane #(.d(d), .R(R)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .load1      (accept),
      .mode       (in_mode),
      .shares_in  (in_shares[i*d +: d]),
      .rnd        (rnd[i*R +: R]),
      .load2      (s2_load),
      .shares_out (out_shares[i*d +: d])
    );
  end

endmodule

// File: tb/tb_msk_ref_sni_pipe.sv
// Directed bench: dut_a (d=2, W=4, CW=2) and dut_b (d=3, W=2, CW=16).
module tb_msk_ref_sni_pipe;
  import msk_ref_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // dut_a: d=2, W=4, R=1
  logic       a_in_valid, a_in_ready, a_in_mode, a_rnd_valid, a_rnd_ready;
  logic       a_out_valid, a_out_ready;
  logic [7:0] a_in_shares, a_out_shares;
  logic [3:0] a_rnd;
  logic [1:0] a_ref_cnt;

  // dut_b: d=3, W=2, R=2
  logic        b_in_valid, b_in_ready, b_in_mode, b_rnd_valid, b_rnd_ready;
  logic        b_out_valid, b_out_ready;
  logic [5:0]  b_in_shares, b_out_shares;
  logic [3:0]  b_rnd;
  logic [15:0] b_ref_cnt;

  msk_ref_sni_pipe #(.d(2), .W(4), .CW(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_shares(a_in_shares), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready),
    .rnd(a_rnd), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_shares(a_out_shares), .ref_cnt(a_ref_cnt)
  );

  msk_ref_sni_pipe #(.d(3), .W(2), .CW(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_shares(b_in_shares), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
    .rnd(b_rnd), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_shares(b_out_shares), .ref_cnt(b_ref_cnt)
  );

  typedef struct {
    logic       mode;
    logic [7:0] sh;
    logic [3:0] rn;
    logic [7:0] exp;
  } vec_t;

  vec_t ta [8];
  vec_t tb [3];
  vec_t st [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [D_MAX-1:0] m;
    logic [R_MAX-1:0] r;
    int sent, got, pulses;

    // mode, in_shares, rnd, expected out (lane mask = {r,r} per lane for d=2)
    ta[0] = '{1'b1, 8'h01, 4'h1, 8'h02};
    ta[1] = '{1'b0, 8'hA5, 4'hF, 8'hA5};
    ta[2] = '{1'b1, 8'hA5, 4'hF, 8'h5A};
    ta[3] = '{1'b1, 8'h00, 4'hA, 8'hCC};
    ta[4] = '{1'b1, 8'hFF, 4'h5, 8'hCC};
    ta[5] = '{1'b0, 8'h3C, 4'h0, 8'h3C};
    ta[6] = '{1'b1, 8'h3C, 4'h0, 8'h3C};
    ta[7] = '{1'b1, 8'h12, 4'h9, 8'hD1};
    // d=3 lane mask = {r0^r1, r1, r0}
    tb[0] = '{1'b1, 8'b00_000000, 4'b1001, 8'b00_110101};
    tb[1] = '{1'b1, 8'b00_111010, 4'b1110, 8'b00_100100};
    tb[2] = '{1'b0, 8'b00_101011, 4'b0000, 8'b00_101011};
    st[0] = '{1'b1, 8'h01, 4'h1, 8'h02};
    st[1] = '{1'b1, 8'h80, 4'h8, 8'h40};
    st[2] = '{1'b1, 8'h55, 4'h3, 8'h5A};

    rst_n = 1'b0;
    a_in_valid = 0; a_in_mode = 0; a_in_shares = 0; a_rnd_valid = 0; a_rnd = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_mode = 0; b_in_shares = 0; b_rnd_valid = 0; b_rnd = 0; b_out_ready = 1;

    // Package functions
    check("r_d2", 64'(ref_n_rnd(2)), 64'd1);
    check("r_d6", 64'(ref_n_rnd(6)), 64'd7);
    check("r_d12", 64'(ref_n_rnd(12)), 64'd20);
    check("r_d16", 64'(ref_n_rnd(16)), 64'd32);
    m = ref_mask(4, 32'h1);
    check("mask_d4", 64'(m[3:0]), 64'h3);
    for (int dd = 2; dd <= 16; dd++) begin
      for (int t = 0; t < 4; t++) begin
        r = {$urandom, $urandom};
        m = ref_mask(dd, r);
        m = m & 16'((32'h1 << dd) - 1);
        check($sformatf("mask_zero_sum_d%0d", dd), 64'(^m), 64'd0);
      end
    end

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_shares", 64'(a_out_shares), 64'd0);
    check("rst_ref_cnt", 64'(a_ref_cnt), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);

    // Full-throughput table on dut_a
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k >= 2) begin
        check($sformatf("tbl_valid_%0d", k - 2), 64'(a_out_valid), 64'd1);
        check($sformatf("tbl_out_%0d", k - 2), 64'(a_out_shares), 64'(ta[k-2].exp));
      end
      if (k < 8) begin
        a_in_valid = 1; a_in_mode = ta[k].mode; a_in_shares = ta[k].sh;
        a_rnd = ta[k].rn; a_rnd_valid = ta[k].mode;
      end else begin
        a_in_valid = 0; a_rnd_valid = 0;
      end
      #1;
      if (k < 8) begin
        check($sformatf("tbl_in_ready_%0d", k), 64'(a_in_ready), 64'd1);
        check($sformatf("tbl_rnd_ready_%0d", k), 64'(a_rnd_ready), 64'(ta[k].mode));
      end
    end
    tick();
    check("tbl_drained", 64'(a_out_valid), 64'd0);
    check("tbl_ref_cnt", 64'(a_ref_cnt), 64'd2);

    // Stall: out_ready low for cycles 0..4, three back-to-back refresh inputs
    sent = 0; got = 0; pulses = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (cyc >= 2 && cyc <= 4) begin
        check("stall_valid_hold", 64'(a_out_valid), 64'd1);
        check("stall_out_hold", 64'(a_out_shares), 64'(st[0].exp));
      end
      a_out_ready = (cyc >= 5);
      a_in_valid = (sent < 3); a_in_mode = 1; a_rnd_valid = 1;
      a_in_shares = (sent < 3) ? st[sent].sh : 8'h00;
      a_rnd = (sent < 3) ? st[sent].rn : 4'h0;
      #1;
      if (a_rnd_ready) pulses++;
      if (a_in_valid && a_in_ready) sent++;
      if (a_out_valid && a_out_ready) begin
        if (got < 3) check($sformatf("stall_order_%0d", got), 64'(a_out_shares), 64'(st[got].exp));
        else check("stall_extra_output", 64'(got), 64'd2);
        got++;
      end
      if (cyc == 4) begin
        check("stall_in_ready_low", 64'(a_in_ready), 64'd0);
        check("stall_accepts", 64'(sent), 64'd2);
        check("stall_rnd_pulses", 64'(pulses), 64'd2);
      end
    end
    a_in_valid = 0; a_rnd_valid = 0; a_out_ready = 1;
    check("stall_got_all", 64'(got), 64'd3);
    check("stall_rnd_total", 64'(pulses), 64'd3);
    check("ref_cnt_wrap", 64'(a_ref_cnt), 64'd1);

    // Randomness starvation
    for (int c = 0; c < 4; c++) begin
      tick();
      a_in_valid = 1; a_in_mode = 1; a_rnd_valid = 0; a_in_shares = 8'hFF; a_rnd = 4'hF;
      #1;
      check("starve_in_ready", 64'(a_in_ready), 64'd0);
      check("starve_rnd_ready", 64'(a_rnd_ready), 64'd0);
      check("starve_out_valid", 64'(a_out_valid), 64'd0);
    end
    a_in_mode = 0;
    #1;
    check("bypass_no_rnd_needed", 64'(a_in_ready), 64'd1);
    a_in_valid = 0;
    repeat (2) begin
      tick();
      check("starve_no_bubble", 64'(a_out_valid), 64'd0);
    end
    check("starve_ref_cnt", 64'(a_ref_cnt), 64'd1);

    // Reset while both stages are full
    a_out_ready = 0;
    tick();
    a_in_valid = 1; a_in_mode = 1; a_rnd_valid = 1; a_in_shares = 8'h0F; a_rnd = 4'h3;
    tick();
    a_in_shares = 8'hF0; a_rnd = 4'hC;
    tick();
    a_in_valid = 0; a_rnd_valid = 0;
    #1;
    check("full_in_ready_low", 64'(a_in_ready), 64'd0);
    check("full_out_valid", 64'(a_out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_out_shares", 64'(a_out_shares), 64'd0);
    check("mid_rst_ref_cnt", 64'(a_ref_cnt), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    a_out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_no_stale", 64'(a_out_valid), 64'd0);
    end

    // d=3 table on dut_b
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k >= 2) begin
        check($sformatf("b_valid_%0d", k - 2), 64'(b_out_valid), 64'd1);
        check($sformatf("b_out_%0d", k - 2), 64'(b_out_shares), 64'(tb[k-2].exp[5:0]));
        for (int l = 0; l < 2; l++)
          check($sformatf("b_parity_%0d_%0d", k - 2, l),
                64'(^b_out_shares[3*l +: 3]), 64'(^tb[k-2].sh[3*l +: 3]));
      end
      if (k < 3) begin
        b_in_valid = 1; b_in_mode = tb[k].mode; b_in_shares = tb[k].sh[5:0];
        b_rnd = tb[k].rn; b_rnd_valid = tb[k].mode;
      end else begin
        b_in_valid = 0; b_rnd_valid = 0;
      end
      #1;
      if (k < 3) check($sformatf("b_rnd_ready_%0d", k), 64'(b_rnd_ready), 64'(tb[k].mode));
    end
    tick();
    check("b_ref_cnt", 64'(b_ref_cnt), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/msk_ref_sni_pipe.md
Name: msk_ref_sni_pipe

Overview:
- Multi-bit, stream-handshaked successor of the single-bit SNI refresh gadget.
- Refreshes W independent d-share bits per transfer using fresh randomness, behind a 2-stage valid/ready pipeline.
- Randomness arrives through its own handshake, and each random word is consumed exactly once.
- Per-transfer bypass mode; counts refresh transfers; sits between masked S-box/linear layers and state registers.

Parameters:
- d, 2, number of shares (supported 2..16; elaboration error otherwise)
- W, 8, number of masked bits per transfer (lanes), >=1
- CW, 16, width of refresh transfer counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transfer request
- in_ready  out  1  block can accept input
- in_mode  in  1  1=refresh, 0=bypass (no masking, no randomness)
- in_shares  in  W*d  sharing; bit i*d+j = share j of lane i
- rnd_valid  in  1  random word available
- rnd_ready  out  1  random word consumed this cycle
- rnd  in  W*R  fresh randomness, R=ref_n_rnd(d); lane i uses rnd[i*R +: R]
- out_valid  out  1  output sharing valid
- out_ready  in  1  downstream accepts
- out_shares  out  W*d  refreshed sharing, same packing as input
- ref_cnt  out  CW  number of refresh-mode output transfers, wraps mod 2^CW

Behaviour:
- Reset (async assert, sync release): stage-1 valid, out_valid, all share/mask registers, ref_cnt = 0; out_shares = 0.
- R per d (package table): 2:1, 3:2, 4:4, 5:5, 6:7, 7:9, 8:11, 9:12, 10:15, 11:17, 12:20, 13..16:2d.
- Mask m(d, r) per lane (package function), XOR of mask shares = 0. Constructions:
  - d=2: {r0,r0}.
  - d=3: {r0^r1, r1, r0}.
  - d=4,5: r ^ rotl1(r) on r[d-1:0].
  - d>=6: rotated ring plus the fixed second-layer pairs from the package table.
- Stage 1 (on accept): registers in_shares, mode, and mask (m or 0 for bypass).
- Stage 2: out_shares <= sh1 ^ mask1. Randomness never recombines with shares combinationally before a register.
- Handshake rules:
  - s2_load = v1 && (!out_valid || out_ready).
  - s1_free = !v1 || s2_load.
  - in_ready = s1_free && (rnd_valid || !in_mode).
  - rnd_ready = in_valid && in_ready && in_mode.
  - No combinational path from in_valid to in_ready, or from rnd_ready to rnd_valid.
- Bypass transfer: rnd_ready=0, rnd_valid ignored, output equals input after latency.
- Latency: acceptance in cycle t -> out_valid in cycle t+2 if unstalled. Full throughput: 1 transfer/cycle.
- Stall: out_valid && !out_ready holds out_shares and out_valid stable; stage 1 holds and in_ready drops once both stages are full.
- Randomness starvation: refresh-mode in_valid with rnd_valid=0 -> in_ready=0, nothing registered, no bubble data leaked.
- ref_cnt increments on out_valid && out_ready when the carried mode=1; wraps from 2^CW-1 to 0.
- Reset mid-operation discards both stages; no partial output is produced after release.
- Stage registers always latch on load even if data are unchanged (no clock-gating on share equality).

Decomposition:
- Package msk_ref_pkg holds:
  - function ref_n_rnd(d)
  - function ref_mask(d, r) returning d bits
  - the d>=6 second-layer index tables
  - range-check constant D_MAX=16
- Sub-module msk_ref_lane (one lane: mask generation and stage regs, data path only), instantiated W times. Handshake control is kept in the top level.

Test Plan:
- d=2, W=1, refresh: in=2'b01, rnd=1, out_ready=1 -> cycle t+2 out_valid=1, out=2'b10, rnd_ready pulsed once, ref_cnt=1.
- d=3, W=2, refresh: in=6'b000_000, rnd=4'b10_01 -> out lane0=3'b101, lane1=3'b110; XOR per lane preserved.
- Bypass: in_mode=0, rnd_valid=0, in=0xA5 (d=2, W=4) -> out=0xA5 at t+2, rnd_ready never 1, ref_cnt unchanged.
- Stall: 3 back-to-back refresh inputs, out_ready=0 for 5 cycles -> in_ready low after 2 accepts, out stable, exactly 2 rnd_ready pulses; on release all 3 emerge in order.
- Starvation + wrap: rnd_valid=0 for 4 cycles with in_valid=1 -> no accept; CW=2 after 5 refresh outputs -> ref_cnt=1.
- rst_n low while both stages full -> out_valid=0 and out=0 immediately; after release no stale output.
